// File: rtl/dip_switch_debouncer.sv
// dip_switch_debouncer
//
// Conditions the raw, asynchronous and mechanically bouncing DIP-switch pins
// for the subsystem's GPIO input. Each bit is synchronised into the sys_clk
// domain and then debounced on its own. Every accepted level change is also
// recorded in a sticky mask, which drives a level interrupt so host software
// can poll or acknowledge switch events.
//
// Ports
//   sys_clk            : single clock, all logic on its rising edge
//   reset              : asynchronous, active-high reset
//   dip_raw_i          : raw switch pins, asynchronous to sys_clk
//   change_ack_i       : level-sampled acknowledge, clears the whole change mask
//   dip_stable_o       : debounced switch levels
//   dip_change_o       : one-cycle pulse whenever any stable bit updates
//   dip_change_mask_o  : sticky mask of bits changed since the last acknowledge
//   irq_o              : OR of dip_change_mask_o (no extra register stage)

module dip_switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dip_raw_i,
  input  logic             change_ack_i,
  output logic [WIDTH-1:0] dip_stable_o,
  output logic             dip_change_o,
  output logic [WIDTH-1:0] dip_change_mask_o,
  output logic             irq_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  // The counter never needs to exceed DEBOUNCE_CYCLES-1, so $clog2 bits suffice.
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_ff [SYNC_STAGES];

  logic [WIDTH-1:0] sync;
  logic [CNT_W-1:0] count      [WIDTH];
  logic [CNT_W-1:0] count_next [WIDTH];
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] new_bits;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] mask_next;
  logic             change;

  // Multi-flop synchroniser chain bringing the raw pins into sys_clk.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_ff[s] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_ff[0] <= dip_raw_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_ff[s] <= sync_ff[s-1];
      end
    end
  end

  assign sync = sync_ff[SYNC_STAGES-1];

  // Per-bit debounce decision: count consecutive disagreement cycles and
  // accept the synchronised level once the run reaches DEBOUNCE_CYCLES.
  always_comb begin
    new_bits = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      count_next[i] = CNT_ZERO;
      if (sync[i] == stable[i]) begin
        // Any cycle of agreement throws away a partial count (glitch rejection).
        count_next[i] = CNT_ZERO;
      end else if (count[i] == CNT_MAX) begin
        count_next[i] = CNT_ZERO;
        new_bits[i]   = 1'b1;
      end else begin
        count_next[i] = count[i] + CNT_ONE;
      end
    end
    // An accepted bit always flips, because acceptance needs disagreement.
    stable_next = stable ^ new_bits;
  end

  // Sticky change mask: an acknowledge wipes older bits, while bits that
  // update in the same cycle still land in the mask.
  always_comb begin
    mask_next = {WIDTH{1'b0}};
    if (change_ack_i) begin
      mask_next = new_bits;
    end else begin
      mask_next = mask | new_bits;
    end
  end

  // Debounce counters, stable levels, change pulse and mask registers.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        count[i] <= CNT_ZERO;
      end
      stable <= {WIDTH{1'b0}};
      change <= 1'b0;
      mask   <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        count[i] <= count_next[i];
      end
      stable <= stable_next;
      change <= |new_bits;
      mask   <= mask_next;
    end
  end

  assign dip_stable_o      = stable;
  assign dip_change_o      = change;
  assign dip_change_mask_o = mask;
  // The interrupt is decoded straight from the mask register, so it adds
  // no latency beyond the mask itself.
  assign irq_o             = |mask;

endmodule

// File: tb/tb_dip_switch_debouncer.sv
// tb_dip_switch_debouncer
//
// Directed bench for dip_switch_debouncer with WIDTH=4, SYNC_STAGES=2 and
// DEBOUNCE_CYCLES=16. A window-based reference model predicts every output
// on every cycle. Hand-computed expectations at the key edges of each
// scenario pin the model itself.

module tb_dip_switch_debouncer;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int HIST = 4096;

  logic         sys_clk = 1'b0;
  logic         reset;
  logic [W-1:0] dip_raw_i;
  logic         change_ack_i;
  logic [W-1:0] dip_stable_o;
  logic         dip_change_o;
  logic [W-1:0] dip_change_mask_o;
  logic         irq_o;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  int p0;

  dip_switch_debouncer #(
    .WIDTH(W),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .dip_raw_i(dip_raw_i),
    .change_ack_i(change_ack_i),
    .dip_stable_o(dip_stable_o),
    .dip_change_o(dip_change_o),
    .dip_change_mask_o(dip_change_mask_o),
    .irq_o(irq_o)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model ----------------
  // hist[n] holds the raw value sampled at the n-th edge since reset.
  // The debouncer sees that sample SYNC edges later. A bit is accepted at
  // edge n when its delayed value was identical over the last DEB edges
  // and differs from the current stable level.
  logic [W-1:0] hist [HIST];
  int           ecnt = 0;
  logic [W-1:0] m_stable = '0;
  logic         m_change = 1'b0;
  logic [W-1:0] m_mask = '0;

  function automatic logic [W-1:0] delayed(input int e);
    logic [W-1:0] v;
    if (e - SYNC >= 1 && e - SYNC < HIST) v = hist[e - SYNC];
    else v = '0;
    return v;
  endfunction

  function automatic logic [W-1:0] settle(input int n, input logic [W-1:0] cur);
    logic [W-1:0] upd;
    logic [W-1:0] last;
    logic [W-1:0] samp;
    upd = '0;
    if (n >= DEB) begin
      last = delayed(n);
      upd  = last ^ cur;
      for (int e = n - DEB + 1; e < n; e++) begin
        samp = delayed(e);
        upd  = upd & ~(samp ^ last);
      end
    end
    return upd;
  endfunction

  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ecnt     <= 0;
      m_stable <= '0;
      m_change <= 1'b0;
      m_mask   <= '0;
    end else begin
      ecnt            <= ecnt + 1;
      hist[(ecnt + 1) % HIST] <= dip_raw_i;
      m_stable        <= m_stable ^ settle(ecnt + 1, m_stable);
      m_change        <= |settle(ecnt + 1, m_stable);
      m_mask          <= (change_ack_i ? 4'h0 : m_mask) | settle(ecnt + 1, m_stable);
    end
  end

  // Per-cycle comparison of all outputs against the model, away from the edge.
  always @(negedge sys_clk) begin
    n_cmp = n_cmp + 1;
    if ({dip_stable_o, dip_change_o, dip_change_mask_o, irq_o} !==
        {m_stable, m_change, m_mask, |m_mask}) begin
      n_bad = n_bad + 1;
      $display("FAIL model_cycle t=%0t: got stable=%h chg=%b mask=%h irq=%b, expected stable=%h chg=%b mask=%h irq=%b",
               $time, dip_stable_o, dip_change_o, dip_change_mask_o, irq_o,
               m_stable, m_change, m_mask, |m_mask);
    end
  end

  // Counts change pulses; each high cycle contains exactly one falling edge.
  always @(negedge sys_clk) begin
    if (dip_change_o === 1'b1) pulse_cnt = pulse_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [W-1:0] st, input logic ch,
                           input logic [W-1:0] mk, input logic iq);
    check({name, "_stable"}, 32'(dip_stable_o), 32'(st));
    check({name, "_change"}, 32'(dip_change_o), 32'(ch));
    check({name, "_mask"},   32'(dip_change_mask_o), 32'(mk));
    check({name, "_irq"},    32'(irq_o), 32'(iq));
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset = 1'b1;
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    dip_raw_i    = 4'h0;
    change_ack_i = 1'b0;
    #1;
    check_all("reset_state", 4'h0, 1'b0, 4'h0, 1'b0);
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;

    // 1. Idle after reset
    repeat (100) @(negedge sys_clk);
    check("idle_pulses", 32'(pulse_cnt), 32'd0);
    check_all("idle", 4'h0, 1'b0, 4'h0, 1'b0);

    // 2. Basic change 0 -> 5, visible after edge k+17
    @(negedge sys_clk);
    dip_raw_i = 4'h5;
    p0 = pulse_cnt;
    repeat (17) @(posedge sys_clk);
    #1;
    check("basic_before", 32'(dip_stable_o), 32'h0);
    @(posedge sys_clk);
    #1;
    check_all("basic_land", 4'h5, 1'b1, 4'h5, 1'b1);
    @(posedge sys_clk);
    #1;
    check_all("basic_after", 4'h5, 1'b0, 4'h5, 1'b1);
    @(negedge sys_clk);
    change_ack_i = 1'b1;
    @(negedge sys_clk);
    change_ack_i = 1'b0;
    check_all("basic_ack", 4'h5, 1'b0, 4'h0, 1'b0);
    check("basic_pulses", 32'(pulse_cnt - p0), 32'd1);

    // 3a. bit3 high for 15 cycles only: rejected
    do_reset();
    p0 = pulse_cnt;
    @(negedge sys_clk);
    dip_raw_i = 4'h8;
    repeat (15) @(negedge sys_clk);
    dip_raw_i = 4'h0;
    repeat (40) @(negedge sys_clk);
    check("glitch_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("glitch_stable", 32'(dip_stable_o), 32'h0);

    // 3b. bit0 bouncing every 5 cycles, then held high
    for (int s = 0; s < 10; s++) begin
      @(negedge sys_clk);
      dip_raw_i = (s % 2 == 0) ? 4'h1 : 4'h0;
      repeat (4) @(negedge sys_clk);
    end
    check("bounce_no_event", 32'(pulse_cnt - p0), 32'd0);
    @(negedge sys_clk);
    dip_raw_i = 4'h1;
    repeat (17) @(posedge sys_clk);
    #1;
    check("bounce_before", 32'(dip_stable_o), 32'h0);
    @(posedge sys_clk);
    #1;
    check_all("bounce_land", 4'h1, 1'b1, 4'h1, 1'b1);
    repeat (5) @(negedge sys_clk);
    check("bounce_pulses", 32'(pulse_cnt - p0), 32'd1);

    // 4. Acknowledge in the same edge that bit1's update lands
    @(negedge sys_clk);
    dip_raw_i = 4'h3;
    repeat (17) @(posedge sys_clk);
    @(negedge sys_clk);
    change_ack_i = 1'b1;
    @(posedge sys_clk);
    #1;
    check_all("ack_coincide", 4'h3, 1'b1, 4'h2, 1'b1);
    @(negedge sys_clk);
    change_ack_i = 1'b0;

    // 5. Reset in the middle of a count
    @(negedge sys_clk);
    dip_raw_i = 4'hF;
    repeat (20) @(posedge sys_clk);
    #1;
    check("midrst_pre_stable", 32'(dip_stable_o), 32'hF);
    @(negedge sys_clk);
    dip_raw_i = 4'h0;
    repeat (12) @(posedge sys_clk);
    #3;
    reset = 1'b1;
    #1;
    check_all("midrst_async", 4'h0, 1'b0, 4'h0, 1'b0);
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
    p0 = pulse_cnt;
    repeat (40) @(negedge sys_clk);
    check("midrst_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("midrst_stable", 32'(dip_stable_o), 32'h0);

    // 6. All four bits change in one step
    @(negedge sys_clk);
    dip_raw_i = 4'hF;
    p0 = pulse_cnt;
    repeat (17) @(posedge sys_clk);
    #1;
    check("multi_before", 32'(dip_stable_o), 32'h0);
    @(posedge sys_clk);
    #1;
    check_all("multi_land", 4'hF, 1'b1, 4'hF, 1'b1);
    @(posedge sys_clk);
    #1;
    check("multi_pulse_width", 32'(dip_change_o), 32'd0);
    repeat (20) @(negedge sys_clk);
    check("multi_pulses", 32'(pulse_cnt - p0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dip_switch_debouncer.md
# dip_switch_debouncer

Board-side input conditioning stage that sits directly upstream of the PCIe/DDR3 subsystem's DIP-switch GPIO input. It synchronises the raw, asynchronous, mechanically bouncing `dip_switches_4bits_tri_i` pins into the system clock domain and debounces each bit independently. It presents a clean `dip_stable_o` vector to the GPIO input. It also records which bits changed, holding those bits in a sticky mask with a level interrupt, so host software can poll or acknowledge switch events over PCIe.

## Interface
Parameters:
- `WIDTH`, 4: number of switch bits.
- `SYNC_STAGES`, 2: flip-flop synchroniser depth; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, 1000000: consecutive mismatch cycles required to accept a new level (10 ms at 100 MHz); legal range ≥ 2.

Ports:
- `sys_clk` input, 1 bit: the single clock for the block; all logic is on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `dip_raw_i` input, WIDTH bits: raw switch pins; asynchronous to `sys_clk`.
- `change_ack_i` input, 1 bit: single-cycle acknowledge; clears the entire change mask.
- `dip_stable_o` output, WIDTH bits: debounced switch levels; feeds the subsystem's DIP GPIO input.
- `dip_change_o` output, 1 bit: one-cycle pulse on any stable-bit update.
- `dip_change_mask_o` output, WIDTH bits: sticky mask of bits whose stable value changed since the last acknowledge.
- `irq_o` output, 1 bit: level output, equal to the OR of `dip_change_mask_o`.

## Operation
- **Synchroniser.** Each bit passes through SYNC_STAGES flops, producing `sync[i]`. The synchroniser flops must carry the ASYNC_REG attribute.
- **Per-bit debounce counter.** Counter width is `$clog2(DEBOUNCE_CYCLES)`.
  - While `sync[i] == stable[i]`, the counter is held at 0.
  - While `sync[i] != stable[i]` and the count is below DEBOUNCE_CYCLES-1, the counter increments.
  - When `sync[i] != stable[i]` and the count equals DEBOUNCE_CYCLES-1, `stable[i]` takes `sync[i]` and the counter returns to 0.
  - Any single cycle of agreement during counting restarts the count from 0, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- **Change event.**
  - `new[i]` is 1 in the cycle that `stable[i]` updates.
  - `dip_change_o` is registered and equals the OR of `new`; it is asserted in the same cycle that `dip_stable_o` shows the new value.
  - The mask updates as mask <= (change_ack_i ? 0 : mask) | new. On a simultaneous acknowledge and new change, the new bits survive and all older bits clear.
- **Acknowledge.** `change_ack_i` is level-sampled each cycle. Holding it high clears the mask every cycle while it is high, but any new change is still captured in the mask for that cycle.
- **Independence.** Bits are fully independent. Several bits may update in the same cycle and produce a single `dip_change_o` pulse carrying a multi-bit mask.
- **Power-up behaviour.** `stable` resets to 0. A switch that is ON at power-up is therefore reported as a change after the normal latency. This is the intended power-up event that software reads.

## Timing
- **Reset values.** All outputs are 0: `dip_stable_o` = 0, `dip_change_o` = 0, `dip_change_mask_o` = 0, `irq_o` = 0. Synchroniser flops and counters are also cleared.
- **Reset assertion.** Reset takes effect immediately and asynchronously, including in the middle of a count. The first evaluation after reset is the first rising edge of `sys_clk` after `reset` deasserts.
- **Latency.** A raw level that is steady from rising edge k appears on `dip_stable_o`, together with the `dip_change_o` pulse and the mask bit, at edge k + SYNC_STAGES + DEBOUNCE_CYCLES - 1. The output is visible during the following cycle.
- **Pulse width.** `dip_change_o` is high for exactly one cycle per update event.
- **Interrupt timing.** `irq_o` is combinational from the mask register and adds no extra cycle. It drops in the cycle after the acknowledge edge unless a new change occurs in that same edge.
- **Throughput.** The same bit can produce a new event at most once every DEBOUNCE_CYCLES cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=16, SYNC_STAGES=2, WIDTH=4. Stated latencies are edges counted from the first edge at which the new raw value is steady.
1. **Idle after reset.** Assert reset and release it, then hold raw=4'h0 for 100 cycles → all outputs remain 0 throughout; no pulse.
2. **Basic change.** Drive raw 4'h0→4'h5 and hold → `dip_stable_o`=4'h5 at edge 17. `dip_change_o` pulses for exactly 1 cycle, mask=4'h5, and `irq_o`=1 until acknowledged. Then `change_ack_i`=1 for one cycle → mask=0 and `irq_o`=0 on the next cycle.
3. **Glitch rejection and bounce.**
   - Raise bit3 for 15 cycles, then drop it → no change event.
   - Toggle bit0 every 5 cycles for 50 cycles, then hold it at 1 → exactly one event (stable=4'h1), at edge 17 after the last toggle.
4. **Acknowledge coincident with a change.** With mask=4'h1 pending, assert `change_ack_i` in the same cycle that bit1's update lands → mask=4'h2 and `irq_o` stays 1.
5. **Reset mid-operation.** Start from stable=4'hF with raw moving to 4'h0; assert reset at count 10 → all outputs are 0 immediately without waiting for a clock. Release reset with raw=4'h0 held → no event is produced, because stable is already 0.
6. **Simultaneous multi-bit change.** Drive raw 4'h0→4'hF in one step → a single pulse, mask=4'hF, stable=4'hF at edge 17.
